multicycle_controller: RTL and testbench

FSM controller that sequences a multicycle RV32I datapath over a single shared instruction/data memory port.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives mux selects, write enables and a req/ready memory handshake.
- Provides a memory timeout and a retired-instruction counter.
- Sits between the IR/opcode output and the datapath control inputs.

---
 rtl/multicycle_controller_if.sv | 64 ++++++
 rtl/multicycle_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if
//
// Purpose: bundles the controller-to-datapath control bus of the multicycle
// RV32I core. This covers the instruction-register opcode, the memory req/ready
// handshake, the branch-compare result, every datapath control strobe/select,
// and the debug/status outputs.
//
// Modports:
//   master : the controller; it drives controls and status, and reads
//            opcode, mem_ready and branch_taken.
//   slave  : the datapath/memory side; it is the mirror image of master.
//
// Signals:
//   opcode[6:0]       instruction[6:0] from IR
//   mem_ready         memory accepts request / read data valid
//   branch_taken      branch-compare result, valid in EXEC
//   mem_req, mem_we   memory request / write
//   mem_addr_sel      0: PC, 1: ALU result
//   ir_write          load IR
//   pc_write          update PC
//   pc_src[1:0]       00 PC+4, 01 PC+imm, 10 ALU result
//   alu_src           0: rs2, 1: immediate
//   alu_op[1:0]       00 add, 01 branch, 10 funct decode, 11 JALR
//   reg_write         register file write
//   wb_sel[1:0]       00 ALU, 01 memory data, 10 PC+4
//   state[2:0]        controller state (debug)
//   mem_err           sticky memory-timeout flag
//   trap              illegal-opcode flag
//   instret[CNT_W-1:0] retired-instruction count
// ---------------------------------------------------------------------------
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_we;
  logic             mem_addr_sel;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic [1:0]       wb_sel;
  logic [2:0]       state;
  logic             mem_err;
  logic             trap;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, mem_ready, branch_taken,
    output mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
           alu_src, alu_op, reg_write, wb_sel, state, mem_err, trap, instret
  );

  modport slave (
    output opcode, mem_ready, branch_taken,
    input  mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
           alu_src, alu_op, reg_write, wb_sel, state, mem_err, trap, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Purpose: this FSM sequences a multicycle RV32I datapath that shares one
// instruction/data memory port. Each instruction walks through
// FETCH/DECODE/EXEC/MEM/WB. The FSM times out stalled memory requests and
// counts retired instructions.
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   ctl       multicycle_controller_if.master control bus (see interface)
//
// Parameters:
//   MEM_TIMEOUT  cycles a memory request may wait for mem_ready before ERR
//                (2..255)
//   CNT_W        width of the instret counter
//
// Optional feature macro: ILLEGAL_OP_TRAP_EN
//   defined   : an illegal opcode locks the FSM in TRAP (trap=1) until reset
//   undefined : an illegal opcode retires as a NOP from DECODE; trap is tied 0
// ---------------------------------------------------------------------------
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  multicycle_controller_if.master   ctl
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // One extra bit so that the count+1 compare cannot wrap at MEM_TIMEOUT=255
  localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR: is_legal = 1'b1;
      default:                                          is_legal = 1'b0;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [6:0]       op_q;
  logic [7:0]       wait_cnt_q;
  logic [CNT_W-1:0] instret_q;

  logic             mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
  logic [1:0]       pc_src, alu_op, wb_sel;
  logic             alu_src, reg_write, mem_err, trap;

  logic             op_legal;
  logic             mem_wait;
  logic             timeout;

  assign op_legal = is_legal(ctl.opcode);

  // A memory stall is a FETCH/MEM cycle with mem_ready low. On the stall
  // cycle that would bring the count to the limit, the FSM leaves for ERR.
  // Therefore mem_ready=1 in that same cycle always wins.
  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM)) && !ctl.mem_ready;
  assign timeout  = mem_wait && (({1'b0, wait_cnt_q} + 9'd1) >= TIMEOUT_LIM);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (ctl.mem_ready)  state_d = S_DECODE;
        else if (timeout)   state_d = S_ERR;
      end
      S_DECODE: begin
        if (op_legal) state_d = S_EXEC;
        else begin
`ifdef ILLEGAL_OP_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_BR:        state_d = S_FETCH;
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (ctl.mem_ready) state_d = (op_q == OP_SW) ? S_FETCH : S_WB;
        else if (timeout)  state_d = S_ERR;
      end
      S_WB:     state_d = S_FETCH;
      S_ERR:    state_d = S_ERR;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode: Moore on state/op_q, with ir_write/pc_write gated by
  // mem_ready, and the branch pc_src gated by branch_taken
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    alu_src      = 1'b0;
    alu_op       = 2'b00;
    reg_write    = 1'b0;
    wb_sel       = 2'b00;
    mem_err      = 1'b0;
    trap         = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = ctl.mem_ready;
      end
      S_DECODE: begin
`ifndef ILLEGAL_OP_TRAP_EN
        // An illegal opcode retires here as a NOP
        pc_write = !op_legal;
`endif
      end
      S_EXEC: begin
        case (op_q)
          OP_R:    begin alu_src = 1'b0; alu_op = 2'b10; end
          OP_I:    begin alu_src = 1'b1; alu_op = 2'b10; end
          OP_LW,
          OP_SW:   begin alu_src = 1'b1; alu_op = 2'b00; end
          OP_BR:   begin
            alu_src  = 1'b0;
            alu_op   = 2'b01;
            pc_write = 1'b1;
            pc_src   = ctl.branch_taken ? 2'b01 : 2'b00;
          end
          OP_JALR: begin alu_src = 1'b1; alu_op = 2'b11; end
          default: begin alu_src = 1'b0; alu_op = 2'b00; end
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (op_q == OP_SW);
        pc_write     = (op_q == OP_SW) && ctl.mem_ready;
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        case (op_q)
          OP_LW:   begin wb_sel = 2'b01; pc_src = 2'b00; end
          OP_JAL:  begin wb_sel = 2'b10; pc_src = 2'b01; end
          OP_JALR: begin wb_sel = 2'b10; pc_src = 2'b10; end
          default: begin wb_sel = 2'b00; pc_src = 2'b00; end
        endcase
      end
      S_ERR:  mem_err = 1'b1;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP: trap = 1'b1;
`endif
      default: ;
    endcase
  end

  // Opcode latch, stall counter and retired-instruction counter.
  // Every pc_write cycle is a final cycle that returns to FETCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= 7'd0;
      wait_cnt_q <= 8'd0;
      instret_q  <= '0;
    end else begin
      if (state_q == S_DECODE) op_q <= ctl.opcode;
      // The count restarts on every non-stall cycle. Because no transition
      // goes directly between FETCH and MEM, it is zero on entry to either.
      wait_cnt_q <= mem_wait ? wait_cnt_q + 8'd1 : 8'd0;
      if (pc_write) instret_q <= instret_q + 1'b1;
    end
  end

  assign ctl.mem_req      = mem_req;
  assign ctl.mem_we       = mem_we;
  assign ctl.mem_addr_sel = mem_addr_sel;
  assign ctl.ir_write     = ir_write;
  assign ctl.pc_write     = pc_write;
  assign ctl.pc_src       = pc_src;
  assign ctl.alu_src      = alu_src;
  assign ctl.alu_op       = alu_op;
  assign ctl.reg_write    = reg_write;
  assign ctl.wb_sel       = wb_sel;
  assign ctl.state        = state_q;
  assign ctl.mem_err      = mem_err;
  assign ctl.trap         = trap;
  assign ctl.instret      = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// This is a self-checking bench for multicycle_controller (MEM_TIMEOUT=4,
// CNT_W=32). A vector table holds one instruction per record, with its
// expected latency and final-cycle controls. Records are queued when they are
// issued, and they are popped and compared when the DUT retires the
// instruction. Hand-written sequences cover reset, ready-wins-at-limit, the
// illegal opcode, asynchronous reset mid-MEM, and the memory timeout.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef struct {
    logic [6:0] op;
    logic       bt;
    int         mwait;    // cycles of mem_ready=0 at the start of MEM
    int         lat;      // FETCH..final cycle, inclusive
    logic       chk_ex;
    logic [1:0] ex_op;
    logic       ex_src;
    logic [1:0] pc_src;
    logic [1:0] wb_sel;
    logic       rw;
    logic [2:0] fst;      // state of the final cycle
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  multicycle_controller_if #(.CNT_W(32)) bus();

  multicycle_controller #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctl     (bus)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  int   exp_instret = 0;
  vec_t sb_q[$];
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] ctl_bits();
    return {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_write, bus.pc_write,
            bus.pc_src, bus.alu_src, bus.alu_op, bus.reg_write, bus.wb_sel,
            bus.mem_err, bus.trap};
  endfunction

  // Called at negedge+1 of a FETCH cycle; returns at negedge+1 of the next FETCH
  task automatic run_instr(input vec_t v);
    int   cyc;
    int   waits;
    logic done;
    logic seen_ex;
    logic [1:0] ex_op;
    logic ex_src;
    vec_t e;
    bus.opcode       = v.op;
    bus.branch_taken = v.bt;
    bus.mem_ready    = 1'b1;
    sb_q.push_back(v);
    #1;
    chk("fetch_state", 32'(bus.state), 32'd1);
    cyc = 1; waits = v.mwait; done = 1'b0; seen_ex = 1'b0; ex_op = 2'b00; ex_src = 1'b0;
    while (!done && cyc <= 20) begin
      if (bus.state == 3'd4) begin
        if (waits > 0) begin bus.mem_ready = 1'b0; waits--; end
        else bus.mem_ready = 1'b1;
        #1;
        chk("mem_addr_sel", 32'(bus.mem_addr_sel), 32'd1);
        chk("mem_we", 32'(bus.mem_we), 32'(v.op == OP_SW));
      end
      if (bus.state == 3'd3) begin
        seen_ex = 1'b1; ex_op = bus.alu_op; ex_src = bus.alu_src;
      end
      if (bus.pc_write) begin
        done = 1'b1;
        e = sb_q.pop_front();
        chk("latency", 32'(cyc), 32'(e.lat));
        chk("final_state", 32'(bus.state), 32'(e.fst));
        chk("pc_src", 32'(bus.pc_src), 32'(e.pc_src));
        chk("wb_sel", 32'(bus.wb_sel), 32'(e.wb_sel));
        chk("reg_write", 32'(bus.reg_write), 32'(e.rw));
        if (e.chk_ex) begin
          chk("exec_seen", 32'(seen_ex), 32'd1);
          chk("alu_op", 32'(ex_op), 32'(e.ex_op));
          chk("alu_src", 32'(ex_src), 32'(e.ex_src));
        end
      end else begin
        @(negedge clk); #1;
        cyc++;
      end
    end
    if (!done) begin
      chk("retire_timeout", 32'(cyc), 32'(v.lat));
      void'(sb_q.pop_front());
    end
    bus.mem_ready = 1'b1;
    @(negedge clk); #1;
    exp_instret++;
    chk("instret", bus.instret, 32'(exp_instret));
    chk("next_fetch", 32'(bus.state), 32'd1);
  endtask

  // Returns at negedge+1 of the first FETCH cycle after reset
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk); #1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_outs", 32'(ctl_bits()), 32'd0);
    chk("rst_instret", bus.instret, 32'd0);
    reset_n = 1'b1;
    exp_instret = 0;
    @(negedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          op       bt  mw lat ex  exop  exsrc pcsrc  wb     rw   fst
    tbl[0]  = '{OP_R,    1'b0, 0, 4, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 1'b1, 3'd5};
    tbl[1]  = '{OP_I,    1'b0, 0, 4, 1'b1, 2'b10, 1'b1, 2'b00, 2'b00, 1'b1, 3'd5};
    tbl[2]  = '{OP_LW,   1'b0, 0, 5, 1'b1, 2'b00, 1'b1, 2'b00, 2'b01, 1'b1, 3'd5};
    tbl[3]  = '{OP_SW,   1'b0, 0, 4, 1'b1, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 3'd4};
    tbl[4]  = '{OP_BR,   1'b1, 0, 3, 1'b1, 2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 3'd3};
    tbl[5]  = '{OP_BR,   1'b0, 0, 3, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 3'd3};
    tbl[6]  = '{OP_JAL,  1'b0, 0, 4, 1'b1, 2'b00, 1'b0, 2'b01, 2'b10, 1'b1, 3'd5};
    tbl[7]  = '{OP_JALR, 1'b0, 0, 4, 1'b1, 2'b11, 1'b1, 2'b10, 2'b10, 1'b1, 3'd5};
    tbl[8]  = '{OP_LW,   1'b0, 3, 8, 1'b1, 2'b00, 1'b1, 2'b00, 2'b01, 1'b1, 3'd5};
    tbl[9]  = '{OP_SW,   1'b0, 2, 6, 1'b1, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 3'd4};
    tbl[10] = '{OP_R,    1'b1, 0, 4, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 1'b1, 3'd5};

    reset_n          = 1'b0;
    bus.opcode       = OP_R;
    bus.mem_ready    = 1'b1;
    bus.branch_taken = 1'b0;

    // Reset state, then a single IDLE cycle after release
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_outs", 32'(ctl_bits()), 32'd0);
    chk("rst_instret", bus.instret, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("idle_state", 32'(bus.state), 32'd0);
    chk("idle_outs", 32'(ctl_bits()), 32'd0);
    @(negedge clk); #1;

    for (int i = 0; i < 11; i++) run_instr(tbl[i]);

    // mem_ready arriving on the cycle the limit would be hit: no error
    bus.opcode = OP_R;
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rw_fetch_state", 32'(bus.state), 32'd1);
      chk("rw_ir_write", 32'(bus.ir_write), 32'd0);
      @(negedge clk); #1;
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("rw_ir_write_ready", 32'(bus.ir_write), 32'd1);
    @(negedge clk); #1;
    chk("rw_decode", 32'(bus.state), 32'd2);
    chk("rw_no_err", 32'(bus.mem_err), 32'd0);
    begin
      int c = 0;
      while (!bus.pc_write && c < 10) begin @(negedge clk); #1; c++; end
      chk("rw_retire", 32'(bus.pc_write), 32'd1);
    end
    @(negedge clk); #1;
    exp_instret++;
    chk("rw_instret", bus.instret, 32'(exp_instret));

    // Illegal opcode
    bus.opcode = 7'b0000000;
    @(negedge clk); #1;
    chk("ill_decode", 32'(bus.state), 32'd2);
`ifdef ILLEGAL_OP_TRAP_EN
    chk("ill_no_pcw", 32'(bus.pc_write), 32'd0);
    @(negedge clk); #1;
    chk("trap_state", 32'(bus.state), 32'd7);
    chk("trap_outs", 32'(ctl_bits()), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("trap_hold", 32'(bus.state), 32'd7);
    chk("trap_instret", bus.instret, 32'(exp_instret));
`else
    chk("nop_pcw", 32'(bus.pc_write), 32'd1);
    chk("nop_pc_src", 32'(bus.pc_src), 32'd0);
    chk("nop_trap", 32'(bus.trap), 32'd0);
    @(negedge clk); #1;
    exp_instret++;
    chk("nop_fetch", 32'(bus.state), 32'd1);
    chk("nop_instret", bus.instret, 32'(exp_instret));
`endif
    do_reset();

    // Asynchronous reset in the middle of an SW memory stall
    bus.opcode = OP_SW;
    bus.mem_ready = 1'b1;
    begin
      int c = 0;
      while (bus.state != 3'd4 && c < 10) begin @(negedge clk); #1; c++; end
    end
    bus.mem_ready = 1'b0;
    #1;
    chk("sw_mem_req", 32'(bus.mem_req), 32'd1);
    chk("sw_mem_we", 32'(bus.mem_we), 32'd1);
    @(negedge clk); #2;
    chk("sw_mem_hold", 32'(bus.state), 32'd4);
    reset_n = 1'b0;
    #1;
    chk("arst_state", 32'(bus.state), 32'd0);
    chk("arst_outs", 32'(ctl_bits()), 32'd0);
    chk("arst_instret", bus.instret, 32'd0);
    exp_instret = 0;
    reset_n = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk); #1;
    chk("arst_fetch", 32'(bus.state), 32'd1);

    // Memory timeout in FETCH: ERR after 4 stalled cycles, sticky
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("to_fetch_state", 32'(bus.state), 32'd1);
      @(negedge clk); #1;
    end
    chk("to_err_state", 32'(bus.state), 32'd6);
    chk("to_err_outs", 32'(ctl_bits()), 32'h2);
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("to_err_hold", 32'(bus.state), 32'd6);
    chk("to_err_sticky", 32'(bus.mem_err), 32'd1);
    do_reset();
    chk("post_rst_fetch", 32'(bus.state), 32'd1);
    chk("post_rst_no_err", 32'(bus.mem_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
